// File: rtl/datamem_param.sv
// Byte-addressed, word-organised data memory with a valid/ready request port,
// a registered one-cycle response carrying an error flag, per-byte store
// enables, and a hardware sweep that zeroes the array after reset or on clr.
module datamem_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 65536
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                busy
);

  localparam int NBYTES = DATA_W / 8;
  localparam int BOFF   = $clog2(NBYTES);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WIDX_W = ADDR_W - BOFF;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;

  logic [DATA_W-1:0]  mem [DEPTH];

  logic [WIDX_W-1:0]  word_idx;
  logic [IDX_W-1:0]   mem_idx;
  logic               misaligned;
  logic               out_of_range;
  logic               req_err;
  logic               accept;
  logic               do_store;
  logic               sweep_last;

  // Address decode, handshake and error classification of the current request.
  always_comb begin
    word_idx     = req_addr[ADDR_W-1:BOFF];
    mem_idx      = word_idx[IDX_W-1:0];
    misaligned   = (req_addr[BOFF-1:0] != '0);
    out_of_range = (64'(word_idx) >= 64'(DEPTH));
    req_err      = misaligned | out_of_range;
    req_ready    = (state_q == S_IDLE) && !clr;
    accept       = req_valid && req_ready;
    do_store     = accept && req_we && !req_err;
    sweep_last   = (cnt_q == IDX_W'(DEPTH - 1));
  end

  // Next-state for the sweep FSM and the registered response.
  always_comb begin
    // NOTE: every signal gets a default up front so no path leaves it unassigned, which would infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = accept;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      S_CLEAR: begin
        if (sweep_last) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      S_IDLE: begin
        if (clr) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_CLEAR;
        cnt_d   = '0;
      end
    endcase

    if (accept) begin
      rsp_err_d   = req_err;
      rsp_rdata_d = (!req_we && !req_err) ? mem[mem_idx] : '0;
    end
  end

  // Control and response flops; reset drops any in-flight response and restarts the sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_CLEAR;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Array writes: one zero word per cycle while sweeping, byte-masked stores while idle.
  // NOTE: the array has no reset branch; it is cleared by the sweep, which keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR) begin
      mem[cnt_q] <= '0;
    end else if (do_store) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (req_be[i]) begin
          mem[mem_idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q == S_CLEAR);

endmodule

// File: tb/tb_datamem_param.sv
// Directed bench for datamem_param at DEPTH=16: sweep length, back-to-back
// load/store vectors with byte enables and error cases, clr priority, and
// asynchronous reset in the middle of a sweep.
module tb_datamem_param;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              clr;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [3:0]        req_be;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;

  datamem_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
  endtask

  task automatic drive_idle();
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
  endtask

  // Count edges until busy drops, with req_ready required low throughout.
  task automatic measure_sweep(input string name);
    int  cycles = 0;
    bit  ready_seen = 1'b0;
    while (busy && cycles < 100) begin
      if (req_ready) ready_seen = 1'b1;
      step();
      cycles++;
    end
    check({name, "_len"}, 64'(cycles), 64'(DEPTH));
    check({name, "_ready_low"}, 64'(ready_seen), 64'd0);
  endtask

  // One accepted load with its response checked on the following cycle.
  task automatic load_check(input string name, input logic [31:0] addr,
                            input logic [31:0] exp_data, input logic exp_err);
    drive_req(1'b0, addr, '0, 4'h0);
    step();
    drive_idle();
    check({name, "_valid"}, 64'(rsp_valid), 64'd1);
    check({name, "_rdata"}, 64'(rsp_rdata), 64'(exp_data));
    check({name, "_err"},   64'(rsp_err),   64'(exp_err));
  endtask

  initial begin
    //            we    addr    wdata         be     exp_rdata     exp_err
    vecs[0]  = '{1'b0, 32'h3C, 32'h0,        4'h0,  32'h00000000, 1'b0};
    vecs[1]  = '{1'b1, 32'h08, 32'hDEADBEEF, 4'hF,  32'h00000000, 1'b0};
    vecs[2]  = '{1'b0, 32'h08, 32'h0,        4'h0,  32'hDEADBEEF, 1'b0};
    vecs[3]  = '{1'b1, 32'h08, 32'h0000AA00, 4'h2,  32'h00000000, 1'b0};
    vecs[4]  = '{1'b0, 32'h08, 32'h0,        4'h0,  32'hDEADAAEF, 1'b0};
    vecs[5]  = '{1'b1, 32'h08, 32'h12345678, 4'h0,  32'h00000000, 1'b0};
    vecs[6]  = '{1'b0, 32'h08, 32'h0,        4'h0,  32'hDEADAAEF, 1'b0};
    vecs[7]  = '{1'b1, 32'h00, 32'h55667788, 4'hF,  32'h00000000, 1'b0};
    vecs[8]  = '{1'b0, 32'h06, 32'h0,        4'h0,  32'h00000000, 1'b1};
    vecs[9]  = '{1'b1, 32'h40, 32'h11223344, 4'hF,  32'h00000000, 1'b1};
    vecs[10] = '{1'b0, 32'h00, 32'h0,        4'h0,  32'h55667788, 1'b0};
    vecs[11] = '{1'b1, 32'h02, 32'hFFFFFFFF, 4'hF,  32'h00000000, 1'b1};
    vecs[12] = '{1'b1, 32'h04, 32'hAABBCCDD, 4'h8,  32'h00000000, 1'b0};
    vecs[13] = '{1'b0, 32'h04, 32'h0,        4'h0,  32'hAA000000, 1'b0};

    rst = 1'b1;
    clr = 1'b0;
    drive_idle();
    repeat (3) step();

    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_rsp_err",   64'(rsp_err),   64'd0);
    check("rst_busy",      64'(busy),      64'd1);

    rst = 1'b0;
    measure_sweep("init_sweep");

    // Back-to-back request vectors: each response is checked while the next request is driven.
    for (int i = 0; i < 14; i++) begin
      drive_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be);
      step();
      check($sformatf("vec%0d_valid", i), 64'(rsp_valid), 64'd1);
      check($sformatf("vec%0d_rdata", i), 64'(rsp_rdata), 64'(vecs[i].exp_rdata));
      check($sformatf("vec%0d_err", i),   64'(rsp_err),   64'(vecs[i].exp_err));
    end
    drive_idle();
    step();
    check("hold_valid", 64'(rsp_valid), 64'd0);
    check("hold_rdata", 64'(rsp_rdata), 64'hAA000000);
    check("hold_err",   64'(rsp_err),   64'd0);
    load_check("pre_clr", 32'h08, 32'hDEADAAEF, 1'b0);

    // clr beats a simultaneous request.
    clr = 1'b1;
    drive_req(1'b0, 32'h08, '0, 4'h0);
    #1;
    check("clr_ready_low", 64'(req_ready), 64'd0);
    step();
    clr = 1'b0;
    drive_idle();
    check("clr_no_rsp", 64'(rsp_valid), 64'd0);
    check("clr_busy",   64'(busy),      64'd1);
    measure_sweep("clr_sweep");
    load_check("post_clr", 32'h08, 32'h00000000, 1'b0);

    // Reset in the middle of a sweep, with a nonzero response held beforehand.
    drive_req(1'b1, 32'h00, 32'h00000001, 4'hF);
    step();
    drive_idle();
    load_check("pre_rst", 32'h00, 32'h00000001, 1'b0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (6) step();
    check("midsweep_busy",  64'(busy),      64'd1);
    check("midsweep_rdata", 64'(rsp_rdata), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(rsp_valid), 64'd0);
    check("async_rst_rdata", 64'(rsp_rdata), 64'd0);
    check("async_rst_err",   64'(rsp_err),   64'd0);
    check("async_rst_busy",  64'(busy),      64'd1);
    step();
    rst = 1'b0;
    measure_sweep("rst_sweep");
    load_check("post_rst", 32'h00, 32'h00000000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/datamem_param.md
Name: datamem_param

Overview:
Parametrised, byte-addressed, word-organised data memory for the single-cycle processor's load/store path.
- Replaces fixed-timing memory access with a valid/ready request port and a registered response with error flag.
- Supports per-byte write enables for sub-word stores.
- Clears its array with a hardware sweep state machine after reset or on command; no file preload at run time.

Parameters:
DATA_W, 32, word width in bits; multiple of 8, at least 16.
ADDR_W, 32, byte-address width.
DEPTH, 65536, number of words; power of two.

Ports:
clk  in  1  clock, rising-edge active
rst  in  1  asynchronous, active-high reset
clr  in  1  request a full array clear (pulse, sampled in IDLE)
req_valid  in  1  request present
req_ready  out  1  request accepted this cycle when high together with req_valid
req_we  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data
req_be  in  DATA_W/8  byte enables for stores; bit i covers req_wdata[8i+7:8i]
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DATA_W  load data; 0 for stores and errors
rsp_err  out  1  misaligned or out-of-range access; valid with rsp_valid
busy  out  1  clear sweep in progress

Behaviour:
- Constants:
  - BOFF = log2(DATA_W/8).
  - word index = req_addr >> BOFF.
  - Misaligned when req_addr[BOFF-1:0] != 0.
  - Out of range when word index >= DEPTH.
- Reset (async, rst=1):
  - State goes to CLEAR and the clear counter goes to 0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=1.
  - Array contents are undefined until the sweep completes.
- CLEAR state:
  - One word per cycle: mem[cnt] <= 0, then cnt increments.
  - busy=1, req_ready=0.
  - Leaves for IDLE after writing word DEPTH-1, so the sweep is exactly DEPTH cycles after rst deasserts.
  - The counter never wraps.
- IDLE state:
  - busy=0.
  - req_ready = !clr, combinational.
  - clr=1 in IDLE moves to CLEAR with cnt=0. clr wins over a simultaneous req_valid; that request is not accepted.
  - clr is ignored while already in CLEAR.
- Accepted request (req_valid & req_ready at edge N):
  - Store, no error: each byte i with req_be[i]=1 is written at edge N; bytes with req_be[i]=0 are unchanged. req_be=0 is a legal no-op store.
  - Load, no error: mem[word index] as it stands at edge N, which already includes a store made at edge N-1.
  - Error: no array write. rsp_err=1.
  - Response: rsp_valid=1 for the cycle after edge N.
    - rsp_rdata = load data; 0 for stores and errors.
    - rsp_err as computed above.
  - rsp_valid returns to 0 the next cycle unless another request was accepted.
  - rsp_rdata and rsp_err hold their last values while rsp_valid=0.
- Throughput: one request per cycle in IDLE. There is no back-pressure on the response; the consumer must always take it.
- Reset mid-operation: an in-flight response is dropped (rsp_valid=0), and a partial sweep restarts at 0.
- Display: debug $display is permitted only under `ifdef DATAMEM_DEBUG; it has no timing effect. No # delays in RTL.

Test Plan:
- DEPTH=16. Pulse rst, release -> busy=1 for exactly 16 cycles, req_ready=0 throughout. Then load addr 0x3C -> rsp_rdata=0x00000000, rsp_err=0 one cycle later.
- Full store: store 0xDEADBEEF to 0x08 with be=4'b1111, then load 0x08 on the next cycle -> rsp_rdata=0xDEADBEEF (read-after-write, 1-cycle latency, back-to-back).
- Byte-enable store: after the full store, store 0x0000AA00 to 0x08 with be=4'b0010, then load 0x08 -> 0xDEADAAEF. Store with be=4'b0000, then load -> still 0xDEADAAEF.
- Error accesses, DEPTH=16:
  - Load 0x06 -> rsp_err=1, rsp_rdata=0.
  - Store 0x11223344 to 0x40 -> rsp_err=1. A following load of 0x00 still returns its prior value.
- Clear priority: with 0x08 holding 0xDEADAAEF, assert clr and req_valid together -> req_ready=0, busy for 16 cycles, then load 0x08 -> 0.
- Reset mid-sweep: assert rst at sweep cycle 7 -> outputs zero immediately (asynchronously). After release, busy lasts a full 16 cycles.
